// File: rtl/fcmp_sched.sv
// fcmp_sched: round-robin issue of compare requests from NREQ requesters into
// a two-stage pipeline around an external combinational comparator.
// S1 holds the issued operands (drives cmp_*). S2 registers the comparator
// result (drives res_*). The grant is registered, so req_rdy never depends
// combinationally on any req_vld.
module fcmp_sched #(
   parameter int NREQ = 3,
   parameter int TAGW = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NREQ-1:0]           req_vld,
   output logic [NREQ-1:0]           req_rdy,
   input  logic [NREQ-1:0][81:0]     req_A,
   input  logic [NREQ-1:0][81:0]     req_B,
   input  logic [NREQ-1:0][1:0]      req_fmt,
   input  logic [NREQ-1:0]           req_afm,
   input  logic [NREQ-1:0][TAGW-1:0] req_tag,
   output logic [81:0]               cmp_A,
   output logic [81:0]               cmp_B,
   output logic                      cmp_isSng,
   output logic                      cmp_isDbl,
   output logic                      cmp_isExt,
   output logic                      cmp_afm,
   input  logic [5:0]                cmp_flags,
   output logic                      res_vld,
   input  logic                      res_rdy,
   output logic [5:0]                res_flags,
   output logic [TAGW-1:0]           res_tag,
   output logic [1:0]                res_src,
   output logic                      res_err,
   output logic [15:0]               unord_cnt
);

   localparam logic [1:0] LAST_IDX      = 2'(NREQ - 1);
   localparam logic [5:0] ILLEGAL_FLAGS = 6'b010001;
   localparam logic [1:0] FMT_SNG       = 2'd0;
   localparam logic [1:0] FMT_DBL       = 2'd1;
   localparam logic [1:0] FMT_EXT       = 2'd2;
   localparam logic [1:0] FMT_ILL       = 2'd3;

   logic                 stall;
   logic [NREQ-1:0]      gnt_q;
   logic [NREQ-1:0]      gnt_nxt;
   logic [NREQ-1:0]      acc;
   logic                 accept;
   logic [1:0]           rr_ptr;
   logic [1:0]           ptr_nxt;
   logic [1:0]           acc_src;
   logic [31:0]          cand;
   logic                 found;

   logic [81:0]          sel_A;
   logic [81:0]          sel_B;
   logic [1:0]           sel_fmt;
   logic                 sel_afm;
   logic [TAGW-1:0]      sel_tag;

   logic                 s1_vld;
   logic [TAGW-1:0]      s1_tag;
   logic [1:0]           s1_src;
   logic                 s1_err;

   assign stall   = res_vld & ~res_rdy;
   assign req_rdy = gnt_q & {NREQ{~stall & ~flush}};
   assign acc     = req_vld & req_rdy;
   assign accept  = |acc;

   // Pick the payload of the accepted requester (at most one bit of acc is set).
   always_comb begin
      acc_src = '0;
      sel_A   = '0;
      sel_B   = '0;
      sel_fmt = '0;
      sel_afm = 1'b0;
      sel_tag = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            acc_src = 2'(i);
            sel_A   = req_A[i];
            sel_B   = req_B[i];
            sel_fmt = req_fmt[i];
            sel_afm = req_afm[i];
            sel_tag = req_tag[i];
         end
      end
   end

   // Round-robin pointer: one past the last accepted requester.
   always_comb begin
      ptr_nxt = rr_ptr;
      if (accept) begin
         ptr_nxt = (acc_src == LAST_IDX) ? 2'd0 : acc_src + 2'd1;
      end
   end

   // Next grant: first valid requester searching upward from the updated pointer.
   // Computed from this cycle's req_vld and registered, which keeps req_rdy free
   // of any combinational path from other requesters' valids.
   always_comb begin
      gnt_nxt = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = 32'(ptr_nxt) + k;
         if (cand >= 32'(NREQ)) begin
            cand = cand - 32'(NREQ);
         end
         if (!found && req_vld[cand]) begin
            gnt_nxt[cand] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   // Grant register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt_q  <= '0;
         rr_ptr <= '0;
      end else begin
         gnt_q  <= gnt_nxt;
         rr_ptr <= ptr_nxt;
      end
   end

   // S1: capture the accepted request; hold while stalled; drain when S2 takes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_vld    <= 1'b0;
         cmp_A     <= '0;
         cmp_B     <= '0;
         cmp_isSng <= 1'b0;
         cmp_isDbl <= 1'b0;
         cmp_isExt <= 1'b0;
         cmp_afm   <= 1'b0;
         s1_tag    <= '0;
         s1_src    <= '0;
         s1_err    <= 1'b0;
      end else if (flush) begin
         s1_vld <= 1'b0;
      end else if (accept) begin
         s1_vld    <= 1'b1;
         cmp_A     <= sel_A;
         cmp_B     <= sel_B;
         cmp_isSng <= (sel_fmt == FMT_SNG) || (sel_fmt == FMT_ILL);
         cmp_isDbl <= (sel_fmt == FMT_DBL);
         cmp_isExt <= (sel_fmt == FMT_EXT);
         cmp_afm   <= sel_afm;
         s1_tag    <= sel_tag;
         s1_src    <= acc_src;
         s1_err    <= (sel_fmt == FMT_ILL);
      end else if (!stall) begin
         s1_vld <= 1'b0;
      end
   end

   // S2: register the comparator result; illegal formats get fixed unordered flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_vld   <= 1'b0;
         res_flags <= '0;
         res_tag   <= '0;
         res_src   <= '0;
         res_err   <= 1'b0;
      end else if (flush) begin
         res_vld <= 1'b0;
      end else if (!stall) begin
         res_vld <= s1_vld;
         if (s1_vld) begin
            res_flags <= s1_err ? ILLEGAL_FLAGS : cmp_flags;
            res_tag   <= s1_tag;
            res_src   <= s1_src;
            res_err   <= s1_err;
         end
      end
   end

   // Saturating count of unordered results handed to the consumer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         unord_cnt <= '0;
      end else if (res_vld && res_rdy && res_flags[4] && (unord_cnt != '1)) begin
         unord_cnt <= unord_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fcmp_sched.sv
// tb_fcmp_sched: directed table of compares plus hand-written sequences for
// grant order, stall, flush and reset-in-flight behaviour.
module tb_fcmp_sched;

   localparam int NREQ = 3;
   localparam int TAGW = 9;

   localparam logic [81:0] ZERO  = 82'h0;
   localparam logic [81:0] NZERO = {1'b1, 81'h0};
   localparam logic [81:0] ONE   = {1'b0, 17'h0FFFF, 64'h8000_0000_0000_0000};
   localparam logic [81:0] TWO   = {1'b0, 17'h10000, 64'h8000_0000_0000_0000};
   localparam logic [81:0] NEG1  = {1'b1, 17'h0FFFF, 64'h8000_0000_0000_0000};
   localparam logic [81:0] NAN   = {1'b0, 17'h1FFFF, 64'hC000_0000_0000_0000};

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      flush;
   logic [NREQ-1:0]           req_vld;
   logic [NREQ-1:0]           req_rdy;
   logic [NREQ-1:0][81:0]     req_A;
   logic [NREQ-1:0][81:0]     req_B;
   logic [NREQ-1:0][1:0]      req_fmt;
   logic [NREQ-1:0]           req_afm;
   logic [NREQ-1:0][TAGW-1:0] req_tag;
   logic [81:0]               cmp_A;
   logic [81:0]               cmp_B;
   logic                      cmp_isSng, cmp_isDbl, cmp_isExt, cmp_afm;
   logic [5:0]                cmp_flags;
   logic                      res_vld;
   logic                      res_rdy;
   logic [5:0]                res_flags;
   logic [TAGW-1:0]           res_tag;
   logic [1:0]                res_src;
   logic                      res_err;
   logic [15:0]               unord_cnt;

   int checks = 0;
   int errors = 0;
   int exp_unord = 0;

   fcmp_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_vld(req_vld), .req_rdy(req_rdy),
      .req_A(req_A), .req_B(req_B), .req_fmt(req_fmt),
      .req_afm(req_afm), .req_tag(req_tag),
      .cmp_A(cmp_A), .cmp_B(cmp_B),
      .cmp_isSng(cmp_isSng), .cmp_isDbl(cmp_isDbl), .cmp_isExt(cmp_isExt),
      .cmp_afm(cmp_afm), .cmp_flags(cmp_flags),
      .res_vld(res_vld), .res_rdy(res_rdy), .res_flags(res_flags),
      .res_tag(res_tag), .res_src(res_src), .res_err(res_err),
      .unord_cnt(unord_cnt)
   );

   always #5 clk = ~clk;

   // Stand-in comparator on 82-bit register format: sign, 17-bit exponent, 64-bit significand.
   // Flags {~C, unord, 0, S, Z, unord}; C and S both mean A < B.
   function automatic logic [5:0] fake_cmp(input logic [81:0] a, input logic [81:0] b);
      logic un, lt, eq;
      un = ((a[80:64] == 17'h1FFFF) && (a[62:0] != 63'h0)) ||
           ((b[80:64] == 17'h1FFFF) && (b[62:0] != 63'h0));
      eq = (a == b) || ((a[80:0] == 81'h0) && (b[80:0] == 81'h0));
      if (a[81] != b[81])  lt = a[81];
      else if (a[81])      lt = a[80:0] > b[80:0];
      else                 lt = a[80:0] < b[80:0];
      if (un)      return 6'b110001;
      else if (eq) return 6'b100010;
      else if (lt) return 6'b000100;
      else         return 6'b100000;
   endfunction

   assign cmp_flags = fake_cmp(cmp_A, cmp_B);

   typedef struct {
      logic [1:0]      fmt;
      logic            afm;
      logic [81:0]     a;
      logic [81:0]     b;
      logic [TAGW-1:0] tag;
      logic [5:0]      exp_flags;
      logic            exp_err;
      logic [2:0]      exp_oh;   // {isSng, isDbl, isExt}
   } vec_t;

   vec_t vt[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b0; flush = 1'b0; req_vld = '0; res_rdy = 1'b1;
      step(); step();
      rst = 1'b1;
      #1;
      exp_unord = 0;
   endtask

   // Present one request on requester r, wait (bounded) for its grant, and
   // return one cycle after the accepting edge with req_vld dropped.
   task automatic issue(input int r, input logic [1:0] fmt, input logic afm,
                        input logic [81:0] a, input logic [81:0] b, input logic [TAGW-1:0] tag);
      int n = 0;
      req_A[r] = a; req_B[r] = b; req_fmt[r] = fmt; req_afm[r] = afm; req_tag[r] = tag;
      req_vld[r] = 1'b1;
      #1;
      while (req_rdy[r] !== 1'b1 && n < 20) begin step(); n++; end
      chk("grant_wait", {81'h0, req_rdy[r]}, 82'h1);
      step();
      req_vld[r] = 1'b0;
      #1;
   endtask

   // Two back-to-back requests on requester 0; returns with S1 = second, S2 = first.
   task automatic fill2(input logic [81:0] a0, input logic [81:0] b0, input logic [1:0] f0, input logic [TAGW-1:0] t0,
                        input logic [81:0] a1, input logic [81:0] b1, input logic [1:0] f1, input logic [TAGW-1:0] t1);
      int n = 0;
      req_A[0] = a0; req_B[0] = b0; req_fmt[0] = f0; req_afm[0] = 1'b0; req_tag[0] = t0;
      req_vld[0] = 1'b1;
      #1;
      while (req_rdy[0] !== 1'b1 && n < 20) begin step(); n++; end
      chk("fill_grant", {81'h0, req_rdy[0]}, 82'h1);
      step();
      req_A[0] = a1; req_B[0] = b1; req_fmt[0] = f1; req_tag[0] = t1;
      #1;
      chk("fill_b2b_grant", {81'h0, req_rdy[0]}, 82'h1);
      step();
      req_vld[0] = 1'b0;
      #1;
      chk("fill_res_vld", {81'h0, res_vld}, 82'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ng, nr, n;
      int g_idx[6];
      int g_cyc[6];
      int r_src[6];

      vt[0] = '{2'd1, 1'b0, ONE,  ONE,   9'h101, 6'b100010, 1'b0, 3'b010};
      vt[1] = '{2'd0, 1'b0, ONE,  TWO,   9'h102, 6'b000100, 1'b0, 3'b100};
      vt[2] = '{2'd2, 1'b1, TWO,  ONE,   9'h103, 6'b100000, 1'b0, 3'b001};
      vt[3] = '{2'd1, 1'b0, NAN,  ONE,   9'h104, 6'b110001, 1'b0, 3'b010};
      vt[4] = '{2'd3, 1'b0, ONE,  ONE,   9'h105, 6'b010001, 1'b1, 3'b100};
      vt[5] = '{2'd0, 1'b0, NEG1, ONE,   9'h106, 6'b000100, 1'b0, 3'b100};
      vt[6] = '{2'd1, 1'b1, ZERO, NZERO, 9'h107, 6'b100010, 1'b0, 3'b010};
      vt[7] = '{2'd2, 1'b0, ONE,  NAN,   9'h108, 6'b110001, 1'b0, 3'b001};

      req_A = '0; req_B = '0; req_fmt = '0; req_afm = '0; req_tag = '0;
      rst = 1'b0; flush = 1'b0; req_vld = '0; res_rdy = 1'b1;
      step(); step(); step();

      chk("rst_res_vld",   {81'h0, res_vld}, 82'h0);
      chk("rst_req_rdy",   {79'h0, req_rdy}, 82'h0);
      chk("rst_unord_cnt", {66'h0, unord_cnt}, 82'h0);
      chk("rst_cmp_A",     cmp_A, 82'h0);
      chk("rst_cmp_isSng", {81'h0, cmp_isSng}, 82'h0);
      chk("rst_res_flags", {76'h0, res_flags}, 82'h0);
      chk("rst_res_tag",   {73'h0, res_tag}, 82'h0);
      rst = 1'b1;
      #1;

      // Directed compare table; vector 0 is the single double 1.0 == 1.0 on requester 0.
      for (int i = 0; i < 8; i++) begin
         issue(i % NREQ, vt[i].fmt, vt[i].afm, vt[i].a, vt[i].b, vt[i].tag);
         chk("s1_res_vld_lat1", {81'h0, res_vld}, 82'h0);
         chk("s1_cmp_A", cmp_A, vt[i].a);
         chk("s1_cmp_B", cmp_B, vt[i].b);
         chk("s1_fmt_onehot", {79'h0, cmp_isSng, cmp_isDbl, cmp_isExt}, {79'h0, vt[i].exp_oh});
         chk("s1_cmp_afm", {81'h0, cmp_afm}, {81'h0, vt[i].afm});
         step();
         chk("res_vld_lat2", {81'h0, res_vld}, 82'h1);
         chk("res_flags", {76'h0, res_flags}, {76'h0, vt[i].exp_flags});
         chk("res_tag",   {73'h0, res_tag}, {73'h0, vt[i].tag});
         chk("res_src",   {80'h0, res_src}, 82'(i % NREQ));
         chk("res_err",   {81'h0, res_err}, {81'h0, vt[i].exp_err});
         step();
         if (vt[i].exp_flags[4]) exp_unord++;
         chk("unord_cnt", {66'h0, unord_cnt}, 82'(exp_unord));
         chk("res_drain", {81'h0, res_vld}, 82'h0);
      end

      // Stall with both stages full: everything frozen, no grant.
      fill2(ONE, TWO, 2'd1, 9'h021, TWO, ONE, 2'd0, 9'h022);
      res_rdy = 1'b0;
      req_A[1] = ONE; req_B[1] = ONE; req_fmt[1] = 2'd1; req_tag[1] = 9'h023; req_vld[1] = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("stall_res_vld",   {81'h0, res_vld}, 82'h1);
         chk("stall_res_tag",   {73'h0, res_tag}, 82'h021);
         chk("stall_res_flags", {76'h0, res_flags}, 82'b000100);
         chk("stall_cmp_A",     cmp_A, TWO);
         chk("stall_cmp_isSng", {81'h0, cmp_isSng}, 82'h1);
         chk("stall_req_rdy",   {79'h0, req_rdy}, 82'h0);
         step();
      end
      res_rdy = 1'b1; req_vld[1] = 1'b0;
      #1;
      chk("release_first_tag", {73'h0, res_tag}, 82'h021);
      step();
      chk("release_second_vld",   {81'h0, res_vld}, 82'h1);
      chk("release_second_tag",   {73'h0, res_tag}, 82'h022);
      chk("release_second_flags", {76'h0, res_flags}, 82'b100000);
      step();
      chk("release_empty", {81'h0, res_vld}, 82'h0);

      // Flush with both stages full and a request pending.
      fill2(TWO, ONE, 2'd1, 9'h031, ONE, ONE, 2'd2, 9'h032);
      res_rdy = 1'b0; flush = 1'b1;
      req_A[0] = ONE; req_B[0] = TWO; req_tag[0] = 9'h033; req_vld[0] = 1'b1;
      #1;
      chk("flush_req_rdy", {79'h0, req_rdy}, 82'h0);
      step();
      flush = 1'b0; req_vld[0] = 1'b0; res_rdy = 1'b1;
      #1;
      chk("flush_res_vld", {81'h0, res_vld}, 82'h0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("flush_no_result", {81'h0, res_vld}, 82'h0);
      end
      chk("flush_unord_cnt", {66'h0, unord_cnt}, 82'(exp_unord));

      // All three requesters valid right after reset.
      do_reset();
      for (int r = 0; r < NREQ; r++) begin
         req_A[r] = ONE; req_B[r] = ONE; req_fmt[r] = 2'd1; req_afm[r] = 1'b0; req_tag[r] = 9'(9'h040 + r);
      end
      req_vld = '1;
      #1;
      ng = 0; nr = 0;
      for (int c = 0; c < 24 && (ng < 6 || nr < 6); c++) begin
         if (ng < 6 && (req_vld & req_rdy) != '0) begin
            g_idx[ng] = oh2idx(req_rdy); g_cyc[ng] = c; ng++;
         end
         if (nr < 6 && res_vld) begin
            r_src[nr] = int'(res_src); nr++;
         end
         step();
         if (ng == 6) req_vld = '0;
         #1;
      end
      chk("rr_grant_count",  82'(ng), 82'd6);
      chk("rr_result_count", 82'(nr), 82'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < ng) chk("rr_grant_order", 82'(g_idx[k]), 82'(k % NREQ));
         if (k > 0 && k < ng) chk("rr_back_to_back", 82'(g_cyc[k] - g_cyc[k-1]), 82'd1);
         if (k < nr) chk("rr_result_src", 82'(r_src[k]), 82'(k % NREQ));
      end
      step();

      // Double NaN: unordered flags and one count on handshake.
      issue(0, 2'd1, 1'b0, NAN, TWO, 9'h050);
      step();
      chk("nan_res_flags", {76'h0, res_flags}, 82'b110001);
      chk("nan_unord_before", {66'h0, unord_cnt}, 82'(exp_unord));
      step();
      exp_unord++;
      chk("nan_unord_after", {66'h0, unord_cnt}, 82'(exp_unord));

      // Reset in the middle of a stall.
      fill2(NAN, ONE, 2'd1, 9'h061, ONE, NAN, 2'd1, 9'h062);
      res_rdy = 1'b0;
      #1;
      step(); step();
      chk("midstall_res_tag", {73'h0, res_tag}, 82'h061);
      chk("midstall_unord",   {66'h0, unord_cnt}, 82'(exp_unord));
      rst = 1'b0;
      step();
      chk("rst_mid_res_vld", {81'h0, res_vld}, 82'h0);
      chk("rst_mid_unord",   {66'h0, unord_cnt}, 82'h0);
      chk("rst_mid_cmp_A",   cmp_A, 82'h0);
      chk("rst_mid_res_tag", {73'h0, res_tag}, 82'h0);
      chk("rst_mid_req_rdy", {79'h0, req_rdy}, 82'h0);
      rst = 1'b1; res_rdy = 1'b1; exp_unord = 0;
      for (int r = 0; r < NREQ; r++) req_tag[r] = 9'(9'h070 + r);
      req_vld = '1;
      #1;
      n = 0;
      while ((req_vld & req_rdy) == '0 && n < 20) begin
         chk("rst_mid_no_stale", {81'h0, res_vld}, 82'h0);
         step(); n++;
      end
      chk("post_rst_first_grant", 82'(oh2idx(req_vld & req_rdy)), 82'd0);
      step();
      req_vld = '0;
      step(); step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
